// File: rtl/risc_pcstack.sv
// Program counter with hardware return stack, interrupt entry and sticky stack-error flags.
// Define RISC_PCSTACK_CIRC_EN to make a push onto a full stack overwrite the oldest entry.
module risc_pcstack #(
    parameter int              ADDR_W    = 16,
    parameter int              DEPTH     = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] INTR_VEC  = ADDR_W'(4)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [2:0]                 pcop,
    input  logic [1:0]                 isize,
    input  logic [ADDR_W-1:0]          jaddr,
    input  logic [7:0]                 roff,
    input  logic                       irq,
    input  logic                       err_clr,
    output logic [ADDR_W-1:0]          pc,
    output logic                       irq_ack,
    output logic                       in_isr,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [2:0] OP_CALL = 3'b001;
    localparam logic [2:0] OP_RET  = 3'b010;
    localparam logic [2:0] OP_RETI = 3'b011;
    localparam logic [2:0] OP_JUMP = 3'b100;
    localparam logic [2:0] OP_RJMP = 3'b101;

    logic [ADDR_W-1:0] stack [DEPTH];
    // top is the next write slot; it only differs from sp mod DEPTH in circular mode
    logic [PTR_W-1:0]  top;

    logic signed [7:0] roff_s;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] rel;
    logic [ADDR_W-1:0] top_val;
    logic [ADDR_W-1:0] pc_nxt;
    logic [SP_W-1:0]   sp_nxt;
    logic [PTR_W-1:0]  top_nxt;
    logic              is_none;
    logic              take_irq;
    logic              push;
    logic              pop;
    logic              wr;
    logic              isr_nxt;
    logic              ovf_set;
    logic              unf_set;

    assign full   = (sp == SP_W'(DEPTH));
    assign empty  = (sp == '0);
    assign roff_s = roff;

    always_comb begin
        seq      = pc + ADDR_W'(isize) + ADDR_W'(1);
        rel      = pc + ADDR_W'(roff_s);
        top_val  = stack[top - PTR_W'(1)];
        is_none  = !(pcop inside {OP_CALL, OP_RET, OP_RETI, OP_JUMP, OP_RJMP});
        take_irq = en && is_none && irq && !in_isr;
        push     = en && ((pcop == OP_CALL) || take_irq);
        pop      = en && ((pcop == OP_RET) || (pcop == OP_RETI));
        ovf_set  = push && full;
        unf_set  = pop && empty;
`ifdef RISC_PCSTACK_CIRC_EN
        wr       = push;
`else
        wr       = push && !full;
`endif

        pc_nxt = pc;
        if (en) begin
            case (pcop)
                OP_CALL, OP_JUMP: pc_nxt = jaddr;
                OP_RET, OP_RETI:  pc_nxt = empty ? RESET_VEC : top_val;
                OP_RJMP:          pc_nxt = rel;
                default:          pc_nxt = take_irq ? INTR_VEC : seq;
            endcase
        end

        sp_nxt  = sp;
        top_nxt = top;
        if (wr) begin
            top_nxt = top + PTR_W'(1);
            if (!full) sp_nxt = sp + SP_W'(1);
        end else if (pop && !empty) begin
            top_nxt = top - PTR_W'(1);
            sp_nxt  = sp - SP_W'(1);
        end

        isr_nxt = in_isr;
        if (take_irq) isr_nxt = 1'b1;
        else if (en && (pcop == OP_RETI)) isr_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_VEC;
            sp      <= '0;
            top     <= '0;
            in_isr  <= 1'b0;
            irq_ack <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            sp      <= sp_nxt;
            top     <= top_nxt;
            in_isr  <= isr_nxt;
            irq_ack <= take_irq;
            // a new error in the same cycle as err_clr wins over the clear
            ovf     <= ovf_set || (ovf && !err_clr);
            unf     <= unf_set || (unf && !err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !rst) stack[top] <= seq;
    end
endmodule

// File: tb/tb_risc_pcstack.sv
// Scoreboard bench for risc_pcstack: directed vectors queue expectations, a negedge monitor checks them.
module tb_risc_pcstack;
    localparam logic [2:0] NONE = 3'd0, CALL = 3'd1, RET = 3'd2, RETI = 3'd3, JUMP = 3'd4, RJMP = 3'd5;
    localparam int X = -1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [2:0]  pcop = NONE;
    logic [1:0]  isize = '0;
    logic [15:0] jaddr = '0;
    logic [7:0]  roff = '0;
    logic        irq = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] pc;
    logic        irq_ack, in_isr, full, empty, ovf, unf;
    logic [3:0]  sp;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        int pc, sp, isr, ack, ovf, unf;
    } exp_t;
    exp_t q[$];

    risc_pcstack dut (
        .clk(clk), .rst(rst), .en(en), .pcop(pcop), .isize(isize), .jaddr(jaddr),
        .roff(roff), .irq(irq), .err_clr(err_clr), .pc(pc), .irq_ack(irq_ack),
        .in_isr(in_isr), .sp(sp), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        if (exp >= 0) begin
            checks++;
            if (act != exp) begin
                errors++;
                $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "pc", int'(pc), e.pc);
                chk(e.name, "sp", int'(sp), e.sp);
                chk(e.name, "in_isr", int'(in_isr), e.isr);
                chk(e.name, "irq_ack", int'(irq_ack), e.ack);
                chk(e.name, "ovf", int'(ovf), e.ovf);
                chk(e.name, "unf", int'(unf), e.unf);
                if (e.sp >= 0) begin
                    chk(e.name, "full", int'(full), (e.sp == 8) ? 1 : 0);
                    chk(e.name, "empty", int'(empty), (e.sp == 0) ? 1 : 0);
                end
            end
        end
    end

    task automatic cyc(input string nm, input bit r, input bit e, input logic [2:0] op,
                       input logic [1:0] is, input logic [15:0] ja, input logic [7:0] ro,
                       input bit iq, input bit ec, input int epc, input int esp,
                       input int eisr, input int eack, input int eovf, input int eunf);
        rst = r; en = e; pcop = op; isize = is; jaddr = ja; roff = ro; irq = iq; err_clr = ec;
        @(posedge clk);
        q.push_back('{nm, epc, esp, eisr, eack, eovf, eunf});
        #1;
    endtask

`ifdef RISC_PCSTACK_CIRC_EN
    int ret_exp[8] = '{'h41, 'h44, 'h43, 'h42, 'h41, 'h44, 'h43, 'h42};
`else
    int ret_exp[8] = '{'h44, 'h43, 'h42, 'h41, 'h44, 'h43, 'h42, 'h01};
`endif

    initial begin
        // reset overrides a CALL and irq in flight
        cyc("reset",      1, 1, CALL, 0, 16'h1234, 8'h00, 1, 0, 'h0000, 0, 0, 0, 0, 0);
        cyc("seq1",       0, 1, NONE, 1, 16'h0000, 8'h00, 0, 0, 'h0002, 0, 0, 0, 0, 0);
        cyc("seq2",       0, 1, NONE, 1, 16'h0000, 8'h00, 0, 0, 'h0004, 0, 0, 0, 0, 0);
        cyc("seq3",       0, 1, NONE, 1, 16'h0000, 8'h00, 0, 0, 'h0006, 0, 0, 0, 0, 0);
        cyc("hold",       0, 0, NONE, 1, 16'h0000, 8'h00, 1, 0, 'h0006, 0, 0, 0, 0, 0);
        cyc("op7",        0, 1, 3'b111, 0, 16'h0000, 8'h00, 0, 0, 'h0007, 0, 0, 0, 0, 0);
        cyc("jump",       0, 1, JUMP, 0, 16'h0010, 8'h00, 0, 0, 'h0010, 0, 0, 0, 0, 0);
        cyc("call",       0, 1, CALL, 2, 16'h0100, 8'h00, 0, 0, 'h0100, 1, 0, 0, 0, 0);
        cyc("ret",        0, 1, RET,  0, 16'h0000, 8'h00, 0, 0, 'h0013, 0, 0, 0, 0, 0);
        cyc("jump5",      0, 1, JUMP, 0, 16'h0005, 8'h00, 0, 0, 'h0005, 0, 0, 0, 0, 0);
        cyc("rjmp_neg",   0, 1, RJMP, 0, 16'h0000, 8'hF0, 0, 0, 'hFFF5, 0, 0, 0, 0, 0);
        cyc("rjmp_pos",   0, 1, RJMP, 0, 16'h0000, 8'h10, 0, 0, 'h0005, 0, 0, 0, 0, 0);
        cyc("call_irq",   0, 1, CALL, 0, 16'h0200, 8'h00, 1, 0, 'h0200, 1, 0, 0, 0, 0);
        cyc("irq_entry",  0, 1, NONE, 0, 16'h0000, 8'h00, 1, 0, 'h0004, 2, 1, 1, 0, 0);
        cyc("reti",       0, 1, RETI, 0, 16'h0000, 8'h00, 0, 0, 'h0201, 1, 0, 0, 0, 0);
        cyc("ret2",       0, 1, RET,  0, 16'h0000, 8'h00, 0, 0, 'h0006, 0, 0, 0, 0, 0);
        cyc("irq2",       0, 1, NONE, 0, 16'h0000, 8'h00, 1, 0, 'h0004, 1, 1, 1, 0, 0);
        cyc("nested",     0, 1, NONE, 0, 16'h0000, 8'h00, 1, 0, 'h0005, 1, 1, 0, 0, 0);
        cyc("ret_isr",    0, 1, RET,  0, 16'h0000, 8'h00, 0, 0, 'h0007, 0, 1, 0, 0, 0);
        cyc("reti_empty", 0, 1, RETI, 0, 16'h0000, 8'h00, 0, 0, 'h0000, 0, 0, 0, 0, 1);
        cyc("clr_hold",   0, 0, NONE, 0, 16'h0000, 8'h00, 0, 1, 'h0000, 0, 0, 0, 0, 0);
        cyc("reset2",     1, 1, NONE, 0, 16'h0000, 8'h00, 0, 0, 'h0000, 0, 0, 0, 0, 0);

        // return addresses: 0x01, then 0x42,0x43,0x44,0x41,0x42,0x43,0x44,0x41
        for (int k = 1; k <= 9; k++)
            cyc("call9", 0, 1, CALL, 2'((k - 1) % 4), 16'h0040, 8'h00, 0, 0,
                'h0040, (k > 8) ? 8 : k, 0, 0, (k == 9) ? 1 : 0, 0);
        for (int i = 0; i < 8; i++)
            cyc("ret8", 0, 1, RET, 0, 16'h0000, 8'h00, 0, 0, ret_exp[i], 7 - i, 0, 0, 1, 0);
        cyc("ret_unf",    0, 1, RET,  0, 16'h0000, 8'h00, 0, 0, 'h0000, 0, 0, 0, 1, 1);
        cyc("clr_set",    0, 1, RET,  0, 16'h0000, 8'h00, 0, 1, 'h0000, 0, 0, 0, 0, 1);
        cyc("clr",        0, 1, NONE, 0, 16'h0000, 8'h00, 0, 1, 'h0001, 0, 0, 0, 0, 0);

        cyc("jump30",     0, 1, JUMP, 0, 16'h0030, 8'h00, 0, 0, 'h0030, 0, 0, 0, 0, 0);
        cyc("ret_empty",  0, 1, RET,  0, 16'h0000, 8'h00, 0, 0, 'h0000, 0, 0, 0, 0, 1);
        cyc("unf_clr",    0, 1, NONE, 0, 16'h0000, 8'h00, 0, 1, 'h0001, 0, 0, 0, 0, 0);

        rst = 1'b0; en = 1'b0; pcop = NONE; irq = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/risc_pcstack.md
RISC_PCSTACK -- requirements
Module: risc_pcstack

Interface
REQ-001 The parameter ADDR_W SHALL default to 16 and set the program-counter and stack-entry width in bits, with a minimum of 8.
REQ-002 The parameter DEPTH SHALL default to 8 and set the number of return-stack entries, which SHALL be a power of two of at least 2.
REQ-003 The parameter RESET_VEC SHALL default to 0 and set the PC value after reset and after a stack underflow.
REQ-004 The parameter INTR_VEC SHALL default to 16'h0004 and set the PC value on interrupt entry.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  the single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  advance enable; when low, all state holds.
- pcop  in  3  operation: 000 NONE, 001 CALL, 010 RET, 011 RETI, 100 JUMP, 101 RJMP; other codes act as NONE.
- isize  in  2  current instruction size minus one (0..3 means 1..4 bytes).
- jaddr  in  ADDR_W  absolute target for CALL and JUMP.
- roff  in  8  signed relative offset for RJMP.
- irq  in  1  level interrupt request.
- err_clr  in  1  clears the sticky error flags.
- pc  out  ADDR_W  current program counter.
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- in_isr  out  1  interrupt service in progress.
- sp  out  $clog2(DEPTH+1)  current stack occupancy.
- full, empty  out  1 each  occupancy equals DEPTH, and occupancy equals 0.
- ovf, unf  out  1 each  sticky overflow and sticky underflow flags.

Function
REQ-006 The sequential address seq SHALL be pc + isize + 1, computed modulo 2^ADDR_W.
REQ-007 With en=1, the next PC SHALL be: NONE gives seq; JUMP gives jaddr; CALL gives jaddr and pushes seq; RET gives the popped value; RETI gives the popped value and clears in_isr; RJMP gives pc + sign-extended roff, modulo 2^ADDR_W.
REQ-008 A push SHALL write the top-of-stack entry and increment sp; a pop SHALL return the most recent entry and decrement sp, all in the same cycle, so the new PC is visible one cycle after the op.
REQ-009 Interrupt entry SHALL occur only when all of these hold: en=1, pcop is NONE, irq=1 and in_isr=0.
REQ-010 On interrupt entry, the block SHALL push seq, load INTR_VEC into pc, set in_isr, and pulse irq_ack for exactly one cycle.
REQ-011 When irq=1 coincides with any non-NONE pcop, the interrupt SHALL be deferred, and no irq_ack SHALL be issued in that cycle.
REQ-012 In_isr=1 SHALL block nested interrupts; a RET (not RETI) issued while in_isr=1 SHALL leave in_isr set.
REQ-013 On a CALL or interrupt entry while full=1, the PC change SHALL still occur, ovf SHALL be set, and stack handling SHALL follow REQ-019.
REQ-014 On a RET or RETI while empty=1, pc SHALL load RESET_VEC, unf SHALL be set, and sp SHALL stay 0; a RETI in this case SHALL still clear in_isr.
REQ-015 The full and empty outputs SHALL be combinational decodes of sp.
REQ-016 Err_clr=1 SHALL clear ovf and unf on the next edge, regardless of en; if a new error event occurs in the same cycle as err_clr, setting SHALL take precedence over clearing.
REQ-017 With en=0, pc, sp, the stack and in_isr SHALL hold, irq_ack SHALL be 0, and irq SHALL be ignored.

Reset
REQ-018 With rst=1 at a clock edge, the block SHALL set pc=RESET_VEC, sp=0, in_isr=0, irq_ack=0, ovf=0 and unf=0, overriding every other input, including an operation in flight; stack-entry contents SHALL NOT be reset.

Configuration
REQ-019 The macro RISC_PCSTACK_CIRC_EN SHALL select the overflow behaviour.
- When RISC_PCSTACK_CIRC_EN is defined, a push while full SHALL overwrite the oldest entry, with the stack acting as a circular buffer and sp staying at DEPTH.
- When RISC_PCSTACK_CIRC_EN is not defined, a push while full SHALL be discarded, and the existing stack contents and sp SHALL be unchanged.
- In both cases, ovf SHALL be set.

Verification
REQ-020 The bench SHALL cover the following directed scenarios (default parameters):
- Reset then 3 cycles of pcop=NONE with isize=1 -> pc sequence 0x0000, 0x0002, 0x0004, 0x0006.
- pc=0x0010, CALL with jaddr=0x0100 and isize=2 -> pc=0x0100, sp=1; then RET -> pc=0x0013, sp=0.
- pc=0x0005, RJMP with roff=8'hF0 -> pc=0xFFF5.
- irq=1 during a CALL cycle -> no irq_ack that cycle; next NONE cycle at pc=0x0200 with isize=0 -> irq_ack=1, pc=0x0004, in_isr=1; then RETI -> pc=0x0201, in_isr=0.
- 9 consecutive CALLs to 0x0040 -> ovf=1, sp=8. With RISC_PCSTACK_CIRC_EN defined, 8 RETs then return the 2nd..9th return addresses in reverse order; without it, they return the 1st..8th.
- RET at sp=0 from pc=0x0030 -> pc=0x0000, unf=1; err_clr=1 on the next cycle -> unf=0.
